mux_display_ctrl: RTL and testbench

MUX_DISPLAY_CTRL -- requirements
Module: mux_display_ctrl

---
 rtl/mux_display_ctrl_pkg.sv | 43 ++++
 rtl/bin2bcd_seq.sv | 66 ++++++
 rtl/mux_display_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mux_display_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_display_ctrl_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display controller.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package mux_display_ctrl_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Decimal digit to active-low segment pattern; 10-15 never occur and stay dark.
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_OFF;
        endcase
        return p;
    endfunction

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] dabble(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Number of BCD digits needed for a w-bit binary: ceil(w*0.302)+1.
    function automatic int bcd_digits(input int w);
        return (w * 302 + 999) / 1000 + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
// done pulses combinationally in the final busy cycle, with bcd holding the finished result.
module bin2bcd_seq
    import mux_display_ctrl_pkg::*;
#(
    parameter int VAL_W = 14,
    parameter int BCD_D = bcd_digits(VAL_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [VAL_W-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*BCD_D-1:0]   bcd
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]   shreg_r;
    logic [4*BCD_D-1:0] work_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic [4*BCD_D-1:0] adj_s;
    logic [4*BCD_D-1:0] next_s;

    // Correct every nibble, then shift in the next binary bit from the top.
    always_comb begin
        adj_s = '0;
        for (int i = 0; i < BCD_D; i++) begin
            adj_s[4*i +: 4] = dabble(work_r[4*i +: 4]);
        end
        next_s = (adj_s << 1) | {{(4*BCD_D-1){1'b0}}, shreg_r[VAL_W-1]};
    end

    // Conversion state; a start while busy is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= '0;
            work_r  <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else if (busy_r) begin
            work_r  <= next_s;
            shreg_r <= shreg_r << 1;
            cnt_r   <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= 1'b1;
            end
        end else if (start) begin
            shreg_r <= bin;
            work_r  <= '0;
            cnt_r   <= CNT_W'(VAL_W);
            busy_r  <= 1'b1;
        end else begin
            busy_r  <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = busy_r && (cnt_r == CNT_W'(1));
    assign bcd  = next_s;

endmodule

// File: rtl/mux_display_ctrl.sv
// Multiplexed 7-segment display controller: captures a binary value, converts it to
// BCD, and scans the digits with PWM brightness, leading-zero blanking and overflow dashes.
module mux_display_ctrl
    import mux_display_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int VAL_W    = 14,
    parameter int SLOT_CYC = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [VAL_W-1:0]  value,
    input  logic [DIGITS-1:0] dp_in,
    input  logic              blank_lz,
    input  logic [3:0]        bright,
    output logic [6:0]        seg_l,
    output logic              dp_l,
    output logic [DIGITS-1:0] dig_l,
    output logic              busy,
    output logic              ovf
);

    localparam int BCD_D  = bcd_digits(VAL_W);
    localparam int EXT_D  = (BCD_D > DIGITS) ? BCD_D : DIGITS;
    localparam int SLOT_W = $clog2(SLOT_CYC);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PH_DIV = SLOT_CYC / 16;

    logic                conv_busy;
    logic                conv_done;
    logic [4*BCD_D-1:0]  conv_bcd;
    logic [4*EXT_D-1:0]  bcd_ext;
    logic                ovf_s;

    logic [DIGITS-1:0]   dp_cap_r;
    logic [DIGITS-1:0]   dp_disp_r;
    logic [4*DIGITS-1:0] disp_r;
    logic                ovf_r;
    logic [SLOT_W-1:0]   slot_r;
    logic [IDX_W-1:0]    idx_r;

    logic [SLOT_W-1:0]   phase_full_s;
    logic [3:0]          phase_s;
    logic                lit_s;
    logic [DIGITS-1:0]   keep_s;
    logic                lz_seen_s;
    logic [3:0]          cur_digit_s;
    logic [6:0]          seg_s;
    logic                dp_s;
    logic [DIGITS-1:0]   dig_s;

    logic [6:0]          seg_l_r;
    logic                dp_l_r;
    logic [DIGITS-1:0]   dig_l_r;

    bin2bcd_seq #(
        .VAL_W (VAL_W),
        .BCD_D (BCD_D)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Any BCD digit beyond the display width means the value cannot be shown.
    always_comb begin
        bcd_ext = '0;
        bcd_ext[4*BCD_D-1:0] = conv_bcd;
        ovf_s = |(bcd_ext >> (4 * DIGITS));
    end

    // dp bits are captured with the load and published together with the digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_cap_r <= '0;
        end else if (load && !conv_busy) begin
            dp_cap_r <= dp_in;
        end else begin
            dp_cap_r <= dp_cap_r;
        end
    end

    // Display register updates in one step on the edge where the conversion ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_r    <= '0;
            dp_disp_r <= '0;
            ovf_r     <= 1'b0;
        end else if (conv_done) begin
            disp_r    <= bcd_ext[4*DIGITS-1:0];
            dp_disp_r <= dp_cap_r;
            ovf_r     <= ovf_s;
        end else begin
            disp_r    <= disp_r;
            dp_disp_r <= dp_disp_r;
            ovf_r     <= ovf_r;
        end
    end

    // Slot counter and digit index; parked at zero while the display is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_r <= '0;
            idx_r  <= '0;
        end else if (!en) begin
            slot_r <= '0;
            idx_r  <= '0;
        end else if (slot_r == SLOT_W'(SLOT_CYC - 1)) begin
            slot_r <= '0;
            if (idx_r == IDX_W'(DIGITS - 1)) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            slot_r <= slot_r + SLOT_W'(1);
            idx_r  <= idx_r;
        end
    end

    // Digits at or below the most significant nonzero digit stay visible; digit 0 always does.
    always_comb begin
        keep_s    = '0;
        lz_seen_s = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_seen_s = lz_seen_s | (disp_r[4*i +: 4] != 4'd0);
            keep_s[i] = lz_seen_s;
        end
        keep_s[0] = 1'b1;
    end

    // Next output values; slot count 0 is the anti-ghosting gap.
    always_comb begin
        phase_full_s = slot_r / SLOT_W'(PH_DIV);
        phase_s      = phase_full_s[3:0];
        lit_s        = en && (phase_s <= bright) && (slot_r != '0);
        cur_digit_s  = disp_r[{idx_r, 2'b00} +: 4];
        seg_s        = SEG_OFF;
        dp_s         = 1'b1;
        dig_s        = '1;
        if (lit_s) begin
            dig_s = ~(DIGITS'(1) << idx_r);
            if (ovf_r) begin
                seg_s = SEG_DASH;
                dp_s  = 1'b1;
            end else if (blank_lz && !keep_s[idx_r]) begin
                seg_s = SEG_OFF;
                dp_s  = 1'b1;
            end else begin
                seg_s = seg_pattern(cur_digit_s);
                dp_s  = ~dp_disp_r[idx_r];
            end
        end else begin
            dig_s = '1;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_l_r <= SEG_OFF;
            dp_l_r  <= 1'b1;
            dig_l_r <= '1;
        end else begin
            seg_l_r <= seg_s;
            dp_l_r  <= dp_s;
            dig_l_r <= dig_s;
        end
    end

    assign seg_l = seg_l_r;
    assign dp_l  = dp_l_r;
    assign dig_l = dig_l_r;
    assign busy  = conv_busy;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_mux_display_ctrl.sv
// Directed self-checking bench for mux_display_ctrl (DIGITS=4, VAL_W=14, SLOT_CYC=32).
module tb_mux_display_ctrl;

    localparam int DIGITS   = 4;
    localparam int VAL_W    = 14;
    localparam int SLOT_CYC = 32;

    logic              clk;
    logic              rst;
    logic              en;
    logic              load;
    logic [VAL_W-1:0]  value;
    logic [DIGITS-1:0] dp_in;
    logic              blank_lz;
    logic [3:0]        bright;
    logic [6:0]        seg_l;
    logic              dp_l;
    logic [DIGITS-1:0] dig_l;
    logic              busy;
    logic              ovf;

    int total;
    int bad;

    mux_display_ctrl #(
        .DIGITS   (DIGITS),
        .VAL_W    (VAL_W),
        .SLOT_CYC (SLOT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .value    (value),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .bright   (bright),
        .seg_l    (seg_l),
        .dp_l     (dp_l),
        .dig_l    (dig_l),
        .busy     (busy),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-written active-low {g..a} patterns for 0..9.
    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'h40;
            1: p = 7'h79;
            2: p = 7'h24;
            3: p = 7'h30;
            4: p = 7'h19;
            5: p = 7'h12;
            6: p = 7'h02;
            7: p = 7'h78;
            8: p = 7'h00;
            9: p = 7'h10;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    task automatic wait_dig(input logic [3:0] pat, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dig_l != pat && n < 400);
        if (dig_l != pat) check({tag, "_timeout"}, 32'(dig_l), 32'(pat));
    endtask

    // Finish the current lit window, then return the next lit digit's outputs.
    task automatic next_lit(output logic [3:0] d, output logic [6:0] s, output logic p);
        int n;
        n = 0;
        while (dig_l != 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (dig_l == 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        d = dig_l;
        s = seg_l;
        p = dp_l;
        check("one_hot", 32'($countones(~dig_l) <= 1), 32'd1);
    endtask

    task automatic load_val(input logic [VAL_W-1:0] v, input logic [3:0] dp, output int cyc);
        @(negedge clk);
        value = v;
        dp_in = dp;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc  = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0] d;
        logic [6:0] s;
        logic       p;
        int         cyc;
        int         lowc;
        int         highc;

        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        en       = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        blank_lz = 1'b0;
        bright   = 4'd15;
        repeat (3) @(negedge clk);
        check("rst_dig", 32'(dig_l), 32'hF);
        check("rst_seg", 32'(seg_l), 32'h7F);
        check("rst_dp", 32'(dp_l), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        rst = 1'b0;

        wait_dig(4'b1110, "init_d0");
        check("init_d0_seg", 32'(seg_l), 32'(seg_of(0)));

        // 1234 with dp on digit 2
        load_val(14'd1234, 4'b0100, cyc);
        check("busy_1234", 32'(cyc), 32'd14);
        wait_dig(4'b1110, "v1234_d0");
        check("v1234_d0_seg", 32'(seg_l), 32'(seg_of(4)));
        check("v1234_d0_dp", 32'(dp_l), 32'h1);
        next_lit(d, s, p);
        check("v1234_d1_dig", 32'(d), 32'hD);
        check("v1234_d1_seg", 32'(s), 32'(seg_of(3)));
        next_lit(d, s, p);
        check("v1234_d2_dig", 32'(d), 32'hB);
        check("v1234_d2_seg", 32'(s), 32'(seg_of(2)));
        check("v1234_d2_dp", 32'(p), 32'h0);
        next_lit(d, s, p);
        check("v1234_d3_dig", 32'(d), 32'h7);
        check("v1234_d3_seg", 32'(s), 32'(seg_of(1)));

        // 9999, then a load of 5 on the third busy cycle must be ignored
        @(negedge clk);
        value = 14'd9999;
        dp_in = 4'b0000;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc  = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (cyc == 3) begin
                load  = 1'b1;
                value = 14'd5;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check("busy_9999", 32'(cyc), 32'd14);
        @(negedge clk);
        check("ignored_load_idle", 32'(busy), 32'h0);
        wait_dig(4'b1110, "v9999_d0");
        check("v9999_d0_seg", 32'(seg_l), 32'(seg_of(9)));
        wait_dig(4'b0111, "v9999_d3");
        check("v9999_d3_seg", 32'(seg_l), 32'(seg_of(9)));

        // 10000 overflows four digits
        load_val(14'd10000, 4'b0010, cyc);
        check("busy_10000", 32'(cyc), 32'd14);
        @(negedge clk);
        check("ovf_set", 32'(ovf), 32'h1);
        wait_dig(4'b1101, "ovf_d1");
        check("ovf_d1_seg", 32'(seg_l), 32'h3F);
        check("ovf_d1_dp", 32'(dp_l), 32'h1);
        wait_dig(4'b0111, "ovf_d3");
        check("ovf_d3_seg", 32'(seg_l), 32'h3F);

        // 7 with leading-zero blanking, then blanking turned off live
        blank_lz = 1'b1;
        load_val(14'd7, 4'b0000, cyc);
        @(negedge clk);
        check("ovf_clear", 32'(ovf), 32'h0);
        wait_dig(4'b1110, "lz_d0");
        check("lz_d0_seg", 32'(seg_l), 32'(seg_of(7)));
        wait_dig(4'b1101, "lz_d1");
        check("lz_d1_seg", 32'(seg_l), 32'h7F);
        check("lz_d1_dp", 32'(dp_l), 32'h1);
        wait_dig(4'b0111, "lz_d3");
        check("lz_d3_seg", 32'(seg_l), 32'h7F);
        blank_lz = 1'b0;
        wait_dig(4'b1101, "nolz_d1");
        check("nolz_d1_seg", 32'(seg_l), 32'(seg_of(0)));

        // Brightness 3: lit slot counts 1..7, dark 8..31 plus the next slot's count 0
        bright = 4'd3;
        lowc   = 0;
        while (dig_l != 4'hF && lowc < 100) begin
            @(negedge clk);
            lowc++;
        end
        lowc = 0;
        while (dig_l == 4'hF && lowc < 200) begin
            @(negedge clk);
            lowc++;
        end
        lowc = 0;
        while (dig_l != 4'hF && lowc < 100) begin
            lowc++;
            @(negedge clk);
        end
        highc = 0;
        while (dig_l == 4'hF && highc < 100) begin
            highc++;
            @(negedge clk);
        end
        check("pwm_low", 32'(lowc), 32'd7);
        check("pwm_high", 32'(highc), 32'd25);
        bright = 4'd15;

        // Disabled display stays dark but conversion still runs
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("en0_dig", 32'(dig_l), 32'hF);
        check("en0_seg", 32'(seg_l), 32'h7F);
        load_val(14'd42, 4'b0000, cyc);
        check("en0_busy", 32'(cyc), 32'd14);
        check("en0_dig_after", 32'(dig_l), 32'hF);
        en = 1'b1;
        wait_dig(4'b1110, "v42_d0");
        check("v42_d0_seg", 32'(seg_l), 32'(seg_of(2)));
        wait_dig(4'b1101, "v42_d1");
        check("v42_d1_seg", 32'(seg_l), 32'(seg_of(4)));

        // Reset in the middle of a conversion while a digit is lit
        wait_dig(4'b1011, "pre_rst");
        @(negedge clk);
        value = 14'd9999;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_dig", 32'(dig_l), 32'hF);
        check("mid_rst_seg", 32'(seg_l), 32'h7F);
        check("mid_rst_dp", 32'(dp_l), 32'h1);
        check("mid_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_dig(4'b1110, "post_rst_d0");
        check("post_rst_d0_seg", 32'(seg_l), 32'(seg_of(0)));
        load_val(14'd5, 4'b0000, cyc);
        check("post_rst_busy", 32'(cyc), 32'd14);
        wait_dig(4'b1110, "post_rst_v5");
        check("post_rst_v5_seg", 32'(seg_l), 32'(seg_of(5)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
